// File: rtl/btn_event_queue.sv
// Turns five debounced button levels into press/release/repeat event bytes and
// queues them in a FWFT FIFO drained over valid/ready. Define BTN_REPEAT_EN for auto-repeat.
module btn_event_queue #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4:0]                    debounced_btn,
  output logic [7:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          ovf_flag,
  input  logic                          ovf_clr
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_e;

  // ---------------------------------------------------------------------------
  // Edge detection and pending bits
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] r_prev_btn;
  logic [NUM_BTN-1:0] r_press_pend;
  logic [NUM_BTN-1:0] r_rel_pend;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;
  logic [NUM_BTN-1:0] w_rep_pend;
  logic [NUM_BTN-1:0] w_rep_tick;
  logic [NUM_BTN-1:0] w_clr_press;
  logic [NUM_BTN-1:0] w_clr_rel;
  logic [NUM_BTN-1:0] w_clr_rep;
  logic               w_ovf_set;
  logic               r_ovf;

  assign w_rise = debounced_btn & ~r_prev_btn;
  assign w_fall = ~debounced_btn & r_prev_btn;

`ifdef BTN_REPEAT_EN
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0]   r_hold_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_rep_phase;
  logic [NUM_BTN-1:0] r_rep_pend;

  // A tick fires on the edge where the held count has reached its limit;
  // the counter then restarts at 1 so later ticks are REPEAT_CYCLES apart.
  always_comb begin
    w_rep_tick = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_rep_tick[i] = debounced_btn[i] &&
                      (r_hold_cnt[i] == (r_rep_phase[i] ? REPEAT_LIM : HOLD_LIM));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) r_hold_cnt[i] <= '0;
      r_rep_phase <= '0;
      r_rep_pend  <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!debounced_btn[i]) begin
          r_hold_cnt[i]  <= '0;
          r_rep_phase[i] <= 1'b0;
        end else if (w_rep_tick[i]) begin
          r_hold_cnt[i]  <= CNT_W'(1);
          r_rep_phase[i] <= 1'b1;
        end else begin
          r_hold_cnt[i]  <= r_hold_cnt[i] + CNT_W'(1);
        end
      end
      r_rep_pend <= (r_rep_pend & ~w_clr_rep) | w_rep_tick;
    end
  end

  assign w_rep_pend = r_rep_pend;
`else
  assign w_rep_pend = '0;
  assign w_rep_tick = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter: lowest index wins, press > repeat > release within a button
  // ---------------------------------------------------------------------------
  logic [AW:0]   r_count;
  logic          w_arb_valid;
  logic [2:0]    w_arb_idx;
  evt_type_e     w_arb_type;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_evt_byte;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_arb_valid = 1'b0;
    w_arb_idx   = '0;
    w_arb_type  = EVT_NONE;
    // Walk downwards so the lowest pending index is the last one written.
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_press_pend[i] || w_rep_pend[i] || r_rel_pend[i]) begin
        w_arb_valid = 1'b1;
        w_arb_idx   = 3'(i);
        if (r_press_pend[i])    w_arb_type = EVT_PRESS;
        else if (w_rep_pend[i]) w_arb_type = EVT_REPEAT;
        else                    w_arb_type = EVT_RELEASE;
      end
    end
  end

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = evt_valid && evt_ready;
  assign w_push     = w_arb_valid && (!w_full || w_pop);
  assign w_evt_byte = {w_arb_type, 3'b000, w_arb_idx};

  always_comb begin
    w_clr_press = '0;
    w_clr_rel   = '0;
    w_clr_rep   = '0;
    if (w_push) begin
      unique case (w_arb_type)
        EVT_PRESS:   w_clr_press[w_arb_idx] = 1'b1;
        EVT_REPEAT:  w_clr_rep[w_arb_idx]   = 1'b1;
        EVT_RELEASE: w_clr_rel[w_arb_idx]   = 1'b1;
        default:     ;
      endcase
    end
  end

  // A new event is lost only if its pending bit stays set past this edge;
  // one being pushed right now frees the slot for the newcomer.
  assign w_ovf_set = |(w_rise     & r_press_pend & ~w_clr_press) ||
                     |(w_fall     & r_rel_pend   & ~w_clr_rel)   ||
                     |(w_rep_tick & w_rep_pend   & ~w_clr_rep);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_btn   <= '0;
      r_press_pend <= '0;
      r_rel_pend   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_prev_btn   <= debounced_btn;
      r_press_pend <= (r_press_pend & ~w_clr_press) | w_rise;
      r_rel_pend   <= (r_rel_pend & ~w_clr_rel) | w_fall;
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  // NOTE: the storage is reset too, so a reset empties the queue contents and
  // the head byte reads back as zero without gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_evt_byte;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_count = r_count;
  assign evt_data  = r_mem[r_rd_ptr];
  assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed self-checking bench for btn_event_queue (HOLD=20, REPEAT=8, DEPTH=4).
// Repeat expectations follow BTN_REPEAT_EN when it is defined for the build.
module tb_btn_event_queue;

  localparam int HOLD  = 20;
  localparam int REP   = 8;
  localparam int DEPTH = 4;

`ifdef BTN_REPEAT_EN
  localparam logic RPT_V = 1'b1;
`else
  localparam logic RPT_V = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] debounced_btn;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       ovf_flag;
  logic       ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_event_queue #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .debounced_btn(debounced_btn),
    .evt_data     (evt_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_count    (evt_count),
    .ovf_flag     (ovf_flag),
    .ovf_clr      (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks valid and occupancy, and the head byte whenever an entry is expected.
  task automatic expect_q(input string tag, input logic v, input logic [7:0] d, input int c);
    check({tag, ".valid"}, 32'(evt_valid), 32'(v));
    check({tag, ".count"}, 32'(evt_count), 32'(c));
    if (v) check({tag, ".data"}, 32'(evt_data), 32'(d));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    debounced_btn = 5'b00000;
    evt_ready     = 1'b0;
    ovf_clr       = 1'b0;
    step(2);
    expect_q("reset", 1'b0, 8'h00, 0);
    check("reset.data", 32'(evt_data), 32'h0);
    check("reset.ovf", 32'(ovf_flag), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Single press/release on button 2 with the consumer always ready.
    debounced_btn = 5'b00100;
    evt_ready     = 1'b1;
    step(1); expect_q("s1.pend",   1'b0, 8'h00, 0);
    step(1); expect_q("s1.press",  1'b1, 8'h42, 1);
    step(1); expect_q("s1.popped", 1'b0, 8'h00, 0);
    step(2);
    debounced_btn = 5'b00000;
    step(1); expect_q("s1.relpend", 1'b0, 8'h00, 0);
    step(1); expect_q("s1.release", 1'b1, 8'h82, 1);
    step(1); expect_q("s1.empty",   1'b0, 8'h00, 0);

    // All five pressed at once with the consumer stalled: FIFO fills with 0..3.
    evt_ready     = 1'b0;
    debounced_btn = 5'b11111;
    step(5); expect_q("s2.full",    1'b1, 8'h40, 4);
    step(2); expect_q("s2.stalled", 1'b1, 8'h40, 4);
    check("s2.ovf", 32'(ovf_flag), 32'h0);
    // Ready while full: pop and push together keep occupancy at 4.
    evt_ready = 1'b1;
    step(1); expect_q("s2.pushpop", 1'b1, 8'h41, 4);
    step(1); expect_q("s2.d42", 1'b1, 8'h42, 3);
    step(1); expect_q("s2.d43", 1'b1, 8'h43, 2);
    step(1); expect_q("s2.d44", 1'b1, 8'h44, 1);
    step(1); expect_q("s2.empty", 1'b0, 8'h00, 0);
    check("s2.ovf_end", 32'(ovf_flag), 32'h0);
    debounced_btn = 5'b00000;
    step(2); expect_q("s2.r80", 1'b1, 8'h80, 1);
    step(1); expect_q("s2.r81", 1'b1, 8'h81, 1);
    step(1); expect_q("s2.r82", 1'b1, 8'h82, 1);
    step(1); expect_q("s2.r83", 1'b1, 8'h83, 1);
    step(1); expect_q("s2.r84", 1'b1, 8'h84, 1);
    step(1); expect_q("s2.rempty", 1'b0, 8'h00, 0);

    // Hold button 0 for 40 cycles: repeats 20, 28 and 36 cycles after the press byte.
    debounced_btn = 5'b00001;
    step(2);  expect_q("s3.press",  1'b1, 8'h40, 1);
    step(1);  expect_q("s3.idle",   1'b0, 8'h00, 0);
    step(18); expect_q("s3.pre1",   1'b0, 8'h00, 0);
    step(1);  expect_q("s3.rep1",   RPT_V, 8'hC0, RPT_V ? 1 : 0);
    step(8);  expect_q("s3.rep2",   RPT_V, 8'hC0, RPT_V ? 1 : 0);
    step(8);  expect_q("s3.rep3",   RPT_V, 8'hC0, RPT_V ? 1 : 0);
    step(2);
    debounced_btn = 5'b00000;
    step(2);  expect_q("s3.release", 1'b1, 8'h80, 1);
    step(1);  expect_q("s3.empty",   1'b0, 8'h00, 0);

    // Loss: fill the FIFO, then press/release/press button 1 while stalled.
    evt_ready     = 1'b0;
    debounced_btn = 5'b00101;
    step(3);
    debounced_btn = 5'b00000;
    step(3); expect_q("s4.full", 1'b1, 8'h40, 4);
    debounced_btn = 5'b00010;
    step(1);
    debounced_btn = 5'b00000;
    step(1); check("s4.ovf_before", 32'(ovf_flag), 32'h0);
    debounced_btn = 5'b00010;
    step(1); check("s4.ovf_set", 32'(ovf_flag), 32'h1);
    expect_q("s4.kept", 1'b1, 8'h40, 4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("s4.ovf_clr", 32'(ovf_flag), 32'h0);
    evt_ready = 1'b1;
    step(1); expect_q("s4.d42", 1'b1, 8'h42, 4);
    step(1); expect_q("s4.d80", 1'b1, 8'h80, 4);
    step(1); expect_q("s4.d82", 1'b1, 8'h82, 3);
    step(1); expect_q("s4.d41", 1'b1, 8'h41, 2);
    step(1); expect_q("s4.d81", 1'b1, 8'h81, 1);
    step(1); expect_q("s4.empty", 1'b0, 8'h00, 0);
    debounced_btn = 5'b00000;
    step(4); expect_q("s4.idle", 1'b0, 8'h00, 0);
    check("s4.ovf_end", 32'(ovf_flag), 32'h0);

    // Reset mid-queue with three entries, asserted between clock edges.
    evt_ready     = 1'b0;
    debounced_btn = 5'b00111;
    step(4); expect_q("s5.three", 1'b1, 8'h40, 3);
    #3 rst_n = 1'b0;
    #1;
    expect_q("s5.async", 1'b0, 8'h00, 0);
    check("s5.async.data", 32'(evt_data), 32'h0);
    step(1);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    // Buttons held through reset produce presses once it is released.
    step(2); expect_q("s5.p40", 1'b1, 8'h40, 1);
    step(1); expect_q("s5.p41", 1'b1, 8'h41, 1);
    step(1); expect_q("s5.p42", 1'b1, 8'h42, 1);
    step(1); expect_q("s5.empty", 1'b0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
